// File: rtl/sram_axi_mux.sv
// sram_axi_mux: arbitrates N SRAM-like request ports onto one AXI3 master.
// Separate round-robin read/write slots, per-master IDs, read-after-write stall.
module sram_axi_mux #(
  parameter int N_MASTER = 2,
  parameter int IDX_W    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_MASTER-1:0]     req,
  input  logic [N_MASTER-1:0]     wr,
  input  logic [2*N_MASTER-1:0]   size,
  input  logic [4*N_MASTER-1:0]   wstrb,
  input  logic [32*N_MASTER-1:0]  addr,
  input  logic [32*N_MASTER-1:0]  wdata,
  output logic [N_MASTER-1:0]     addr_ok,
  output logic [N_MASTER-1:0]     data_ok,
  output logic [32*N_MASTER-1:0]  rdata,
  output logic [IDX_W-1:0]        arid,
  output logic [31:0]             araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic [1:0]              arlock,
  output logic [3:0]              arcache,
  output logic [2:0]              arprot,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [IDX_W-1:0]        rid,
  input  logic [31:0]             axi_rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  output logic [IDX_W-1:0]        awid,
  output logic [31:0]             awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic [1:0]              awlock,
  output logic [3:0]              awcache,
  output logic [2:0]              awprot,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [IDX_W-1:0]        wid,
  output logic [31:0]             axi_wdata,
  output logic [3:0]              axi_wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [IDX_W-1:0]        bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  logic [N_MASTER-1:0]         busy;
  logic [N_MASTER-1:0]         wpend;
  logic [N_MASTER-1:0][29:0]   wtbl;
  logic [IDX_W-1:0]            rd_ptr;
  logic [IDX_W-1:0]            wr_ptr;
  logic [IDX_W-1:0]            rd_idx;
  logic [IDX_W-1:0]            wr_idx;
  logic [N_MASTER-1:0]         haz;
  logic [N_MASTER-1:0]         rd_cand;
  logic [N_MASTER-1:0]         wr_cand;
  logic [N_MASTER-1:0]         rd_gnt;
  logic [N_MASTER-1:0]         wr_gnt;
  logic [N_MASTER-1:0]         r_hit;
  logic [N_MASTER-1:0]         b_hit;
  logic                        rd_go;
  logic                        wr_go;
  logic                        rd_free;
  logic                        wr_free;
  logic                        unused_resp;

  assign unused_resp = ^{rresp, bresp, rlast};

  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign awlen   = 8'd0;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign wid     = awid;
  assign wlast   = 1'b1;
  assign rready  = 1'b1;
  assign bready  = 1'b1;

  // a slot can take a new request in the cycle its last handshake completes
  assign rd_free = !arvalid || arready;
  assign wr_free = (!awvalid || awready) && (!wvalid || wready);

  // pending-write table holds every write not yet answered by B
  always_comb begin
    haz = '0;
    for (int i = 0; i < N_MASTER; i++)
      for (int j = 0; j < N_MASTER; j++)
        if (wpend[j] && wtbl[j] == addr[32*i+2 +: 30])
          haz[i] = 1'b1;
  end

  assign rd_cand = req & ~wr & ~busy & ~haz;
  assign wr_cand = req & wr & ~busy;

  always_comb begin
    rd_go  = 1'b0;
    wr_go  = 1'b0;
    rd_idx = '0;
    wr_idx = '0;
    rd_gnt = '0;
    wr_gnt = '0;
    for (int k = 0; k < N_MASTER; k++)
      for (int i = 0; i < N_MASTER; i++) begin
        if (rd_free && !rd_go && rd_cand[i] &&
            (int'(rd_ptr) + 1 + k) % N_MASTER == i) begin
          rd_go     = 1'b1;
          rd_idx    = IDX_W'(i);
          rd_gnt[i] = 1'b1;
        end
        if (wr_free && !wr_go && wr_cand[i] &&
            (int'(wr_ptr) + 1 + k) % N_MASTER == i) begin
          wr_go     = 1'b1;
          wr_idx    = IDX_W'(i);
          wr_gnt[i] = 1'b1;
        end
      end
  end

  assign addr_ok = rd_gnt | wr_gnt;

  always_comb begin
    r_hit = '0;
    b_hit = '0;
    for (int i = 0; i < N_MASTER; i++) begin
      r_hit[i] = rvalid && rready && rid == IDX_W'(i);
      b_hit[i] = bvalid && bready && bid == IDX_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      arvalid   <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      arid      <= '0;
      araddr    <= '0;
      arsize    <= '0;
      awid      <= '0;
      awaddr    <= '0;
      awsize    <= '0;
      axi_wdata <= '0;
      axi_wstrb <= '0;
      busy      <= '0;
      wpend     <= '0;
      wtbl      <= '0;
      rd_ptr    <= IDX_W'(N_MASTER - 1);
      wr_ptr    <= IDX_W'(N_MASTER - 1);
      data_ok   <= '0;
      rdata     <= '0;
    end else begin
      if (arready) arvalid <= 1'b0;
      if (awready) awvalid <= 1'b0;
      if (wready)  wvalid  <= 1'b0;
      if (rd_go) begin
        arvalid <= 1'b1;
        rd_ptr  <= rd_idx;
      end
      if (wr_go) begin
        awvalid <= 1'b1;
        wvalid  <= 1'b1;
        wr_ptr  <= wr_idx;
      end
      busy    <= (busy & ~(r_hit | b_hit)) | addr_ok;
      data_ok <= r_hit | b_hit;
      for (int i = 0; i < N_MASTER; i++) begin
        if (r_hit[i]) rdata[32*i +: 32] <= axi_rdata;
        if (rd_gnt[i]) begin
          arid   <= IDX_W'(i);
          araddr <= addr[32*i +: 32];
          arsize <= {1'b0, size[2*i +: 2]};
        end
        if (wr_gnt[i]) begin
          awid      <= IDX_W'(i);
          awaddr    <= addr[32*i +: 32];
          awsize    <= {1'b0, size[2*i +: 2]};
          axi_wdata <= wdata[32*i +: 32];
          axi_wstrb <= wstrb[4*i +: 4];
          wpend[i]  <= 1'b1;
          wtbl[i]   <= addr[32*i+2 +: 30];
        end else if (b_hit[i]) begin
          wpend[i]  <= 1'b0;
        end
      end
    end
  end

endmodule
